result_bus_arbiter: RTL and testbench

//  Producer end of the common result bus. Collects finished results from STATION_COUNT

---
 rtl/result_bus_arbiter.sv | 92 +++++++++
 tb/tb_result_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// Result bus producer: picks up to BUS_COUNT finished stations per cycle in round-robin
// order, frees them combinationally and broadcasts their results on registered lanes.
module result_bus_arbiter #(
    parameter int SIZE               = 32,
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = 2,
    parameter int BUS_COUNT          = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic [STATION_COUNT-1:0]               result_ready,
    input  logic [STATION_COUNT*SIZE-1:0]          result,
    output logic [STATION_COUNT-1:0]               reset_occupied,
    output logic [BUS_COUNT-1:0]                   bus_asserted,
    output logic [BUS_COUNT*STATION_INDEX_SIZE-1:0] bus_source,
    output logic [BUS_COUNT*SIZE-1:0]              bus_value
);

    logic [STATION_INDEX_SIZE-1:0]           rr_pointer;
    logic [STATION_INDEX_SIZE-1:0]           next_pointer_p0;
    logic [SIZE-1:0]                         res_p0 [STATION_COUNT];
    logic [STATION_COUNT-1:0]                avail_p0;
    logic [STATION_COUNT-1:0]                grant_p0;
    logic [BUS_COUNT-1:0]                    lane_vld_p0;
    logic [BUS_COUNT*STATION_INDEX_SIZE-1:0] lane_src_p0;
    logic [BUS_COUNT*SIZE-1:0]               lane_val_p0;

    // Modular station index: base + off wrapped into 0..STATION_COUNT-1 (off <= STATION_COUNT).
    function automatic logic [STATION_INDEX_SIZE-1:0] wrap_index(
        input logic [STATION_INDEX_SIZE-1:0] base,
        input int                            off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= STATION_COUNT) sum = sum - STATION_COUNT;
        return STATION_INDEX_SIZE'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < STATION_COUNT; i++) begin
            res_p0[i] = result[i*SIZE +: SIZE];
        end
    end

    // Stage p0: rotate from rr_pointer; lane k takes the first station not claimed by lanes < k.
    always_comb begin
        logic [STATION_INDEX_SIZE-1:0] idx;
        logic                          found;
        avail_p0        = (reset && !flush) ? result_ready : '0;
        grant_p0        = '0;
        lane_vld_p0     = '0;
        lane_src_p0     = '0;
        lane_val_p0     = '0;
        next_pointer_p0 = rr_pointer;
        idx             = '0;
        found           = 1'b0;
        for (int k = 0; k < BUS_COUNT; k++) begin
            found = 1'b0;
            for (int j = 0; j < STATION_COUNT; j++) begin
                idx = wrap_index(rr_pointer, j);
                if (!found && avail_p0[idx]) begin
                    found                                          = 1'b1;
                    avail_p0[idx]                                  = 1'b0;
                    grant_p0[idx]                                  = 1'b1;
                    lane_vld_p0[k]                                 = 1'b1;
                    lane_src_p0[k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] = idx;
                    lane_val_p0[k*SIZE +: SIZE]                    = res_p0[idx];
                    next_pointer_p0                                = wrap_index(idx, 1);
                end
            end
        end
    end

    assign reset_occupied = grant_p0;

    // Stage p1: registered bus lanes and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_asserted <= '0;
            bus_source   <= '0;
            bus_value    <= '0;
            rr_pointer   <= '0;
        end else begin
            bus_asserted <= lane_vld_p0;
            bus_source   <= lane_src_p0;
            bus_value    <= lane_val_p0;
            rr_pointer   <= flush ? '0 : next_pointer_p0;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench: one single-lane and one dual-lane arbiter driven with directed vectors.
module tb_result_bus_arbiter;

    logic         clock;
    logic         reset;
    logic         flush1, flush2;
    logic [3:0]   ready1, ready2;
    logic [127:0] res;
    logic [3:0]   occ1, occ2;
    logic [0:0]   asserted1;
    logic [1:0]   source1;
    logic [31:0]  value1;
    logic [1:0]   asserted2;
    logic [3:0]   source2;
    logic [63:0]  value2;

    int checks   = 0;
    int failures = 0;

    logic [34:0] q1 [$];
    logic [69:0] q2 [$];
    logic [34:0] m1;
    logic [69:0] m2;

    localparam logic [31:0] V0 = 32'h1000_0000;
    localparam logic [31:0] V1 = 32'h1111_1111;
    localparam logic [31:0] V2 = 32'hDEAD_BEEF;
    localparam logic [31:0] V3 = 32'h3333_3333;

    result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) dut1 (
        .clock(clock), .reset(reset), .flush(flush1), .result_ready(ready1), .result(res),
        .reset_occupied(occ1), .bus_asserted(asserted1), .bus_source(source1), .bus_value(value1)
    );

    result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(2)) dut2 (
        .clock(clock), .reset(reset), .flush(flush2), .result_ready(ready2), .result(res),
        .reset_occupied(occ2), .bus_asserted(asserted2), .bus_source(source2), .bus_value(value2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitors: each registered bus snapshot is compared with the oldest queued expectation.
    always @(posedge clock) begin
        #1;
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            check("bus1_asserted", 64'(asserted1), 64'(m1[34]));
            check("bus1_source", 64'(source1), 64'(m1[33:32]));
            check("bus1_value", 64'(value1), 64'(m1[31:0]));
        end
    end

    always @(posedge clock) begin
        #1;
        if (q2.size() > 0) begin
            m2 = q2.pop_front();
            check("bus2_asserted", 64'(asserted2), 64'(m2[69:68]));
            check("bus2_source", 64'(source2), 64'(m2[67:64]));
            check("bus2_value", value2, m2[63:0]);
        end
    end

    task automatic step1(input logic [3:0] rdy, input logic fl, input logic [3:0] eocc,
                         input logic ea, input logic [1:0] es, input logic [31:0] ev);
        @(negedge clock);
        ready1 = rdy;
        flush1 = fl;
        #1;
        check("occ1", 64'(occ1), 64'(eocc));
        q1.push_back({ea, es, ev});
    endtask

    task automatic step2(input logic [3:0] rdy, input logic fl, input logic [3:0] eocc,
                         input logic [1:0] ea, input logic [3:0] es, input logic [63:0] ev);
        @(negedge clock);
        ready2 = rdy;
        flush2 = fl;
        #1;
        check("occ2", 64'(occ2), 64'(eocc));
        q2.push_back({ea, es, ev});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        flush1 = 1'b0;
        flush2 = 1'b0;
        ready1 = 4'b1111;
        ready2 = 4'b1111;
        res    = {V3, V2, V1, V0};

        // Held in reset with every station ready: nothing granted, nothing broadcast.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("rst_occ1", 64'(occ1), 64'd0);
            check("rst_occ2", 64'(occ2), 64'd0);
            check("rst_asserted1", 64'(asserted1), 64'd0);
            check("rst_asserted2", 64'(asserted2), 64'd0);
            check("rst_value1", 64'(value1), 64'd0);
        end
        @(negedge clock);
        ready1 = 4'b0000;
        ready2 = 4'b0000;
        reset  = 1'b1;

        // Single lane: grant of station 2, then pointer at 3 chooses 3 over 0.
        step1(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, V2);
        step1(4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, V3);
        step1(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0);
        // Stations drop their bit once granted: sweep 0..3 then wrap to 0.
        step1(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, V0);
        step1(4'b1110, 1'b0, 4'b0010, 1'b1, 2'd1, V1);
        step1(4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, V2);
        step1(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, V3);
        step1(4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, V0);
        step1(4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, V1);
        // Flush with pointer at 2: no grant, pointer returns to 0 so station 0 beats 3.
        step1(4'b0110, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd0);
        step1(4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0, V0);
        step1(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0);

        // Reset in mid-cycle clears the bus at once and the pointer (3 -> 0).
        step1(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, V2);
        @(posedge clock);
        #3;
        ready1 = 4'b1111;
        reset  = 1'b0;
        #1;
        check("midrst_asserted1", 64'(asserted1), 64'd0);
        check("midrst_source1", 64'(source1), 64'd0);
        check("midrst_value1", 64'(value1), 64'd0);
        check("midrst_occ1", 64'(occ1), 64'd0);
        @(negedge clock);
        ready1 = 4'b0000;
        reset  = 1'b1;
        step1(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, V1);
        step1(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0);

        // Dual lane: pointer to 3, then 3 on lane0 and 0 on lane1, pointer to 1.
        step2(4'b0100, 1'b0, 4'b0100, 2'b01, {2'd0, 2'd2}, {32'd0, V2});
        step2(4'b1011, 1'b0, 4'b1001, 2'b11, {2'd0, 2'd3}, {V0, V3});
        step2(4'b0011, 1'b0, 4'b0011, 2'b11, {2'd0, 2'd1}, {V0, V1});
        step2(4'b0110, 1'b0, 4'b0110, 2'b11, {2'd2, 2'd1}, {V2, V1});
        // Single ready station: lane1 stays invalid with zeroed fields.
        step2(4'b0010, 1'b0, 4'b0010, 2'b01, {2'd0, 2'd1}, {32'd0, V1});
        step2(4'b1111, 1'b0, 4'b1100, 2'b11, {2'd3, 2'd2}, {V3, V2});
        step2(4'b1111, 1'b1, 4'b0000, 2'b00, 4'd0, 64'd0);
        step2(4'b0011, 1'b0, 4'b0011, 2'b11, {2'd1, 2'd0}, {V1, V0});
        step2(4'b0000, 1'b0, 4'b0000, 2'b00, 4'd0, 64'd0);

        for (int i = 0; i < 10 && (q1.size() > 0 || q2.size() > 0); i++) begin
            @(posedge clock);
            #2;
        end
        checks++;
        if (q1.size() > 0 || q2.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
